wr_port_arbiter: RTL and testbench

//  Shares the DMAC master-write port among NREQ write requesters: text, tag, CKN/AD pass-through and status writeback.

---
 rtl/wr_port_arbiter_pkg.sv | 15 +
 rtl/wr_port_arbiter_rr_pick.sv | 26 ++
 rtl/wr_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_wr_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wr_port_arbiter_pkg.sv
// Shared types and sizing helpers for the DMAC master-write port arbiter.
package wr_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_DRAIN} arb_state_e;

    localparam int DEF_NREQ      = 3;
    localparam int DEF_MAX_BURST = 16;
    localparam int DEF_TIMEOUT   = 1024;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wr_port_arbiter_rr_pick.sv
// Combinational one-hot round-robin selector: first set request at or after ptr, wrapping to 0.
module rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick
);

    logic [N-1:0] at_or_after;
    logic [N-1:0] masked;
    logic [N-1:0] masked_first;
    logic [N-1:0] any_first;

    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign at_or_after[gi] = (PTR_W'(gi) >= ptr);
    end

    // Lowest set bit of the upper window; fall back to the lowest set bit overall.
    assign masked       = req & at_or_after;
    assign masked_first = masked & (~masked + N'(1));
    assign any_first    = req & (~req + N'(1));
    assign pick         = (|masked) ? masked_first : any_first;

endmodule

// File: rtl/wr_port_arbiter.sv
// Round-robin, burst-locked arbiter sharing the DMAC master-write port among NREQ requesters.
// Optional wait-stall watchdog is built only when WR_ARB_WAIT_TIMEOUT_EN is defined.
module wr_port_arbiter
    import wr_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 iClk,
    input  logic                 iRstn,
    input  logic [NREQ-1:0]      req_vld_i,
    input  logic [NREQ*32-1:0]   req_addr_i,
    input  logic [NREQ*32-1:0]   req_data_i,
    input  logic [NREQ-1:0]      req_last_i,
    output logic [NREQ-1:0]      req_rdy_o,
    output logic [NREQ-1:0]      gnt_o,
    output logic [31:0]          oAddress_Master_Write,
    output logic [31:0]          oData_Master_Write,
    output logic                 oWrite_Master_Write,
    input  logic                 iWait_Master_Write,
    output logic                 busy_o,
    input  logic                 clr_timeout_i,
    output logic                 timeout_o
);

    localparam int PTR_W = idx_width(NREQ);
    localparam int CNT_W = idx_width(MAX_BURST);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NREQ - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_e        state_reg, state_next;
    logic [NREQ-1:0]   gnt_reg, gnt_next;
    logic [PTR_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]  beat_cnt_reg, beat_cnt_next;
    logic [31:0]       addr_reg, addr_next;
    logic [31:0]       data_reg, data_next;
    logic              write_reg, write_next;

    logic [NREQ-1:0]   pick;
    logic [PTR_W-1:0]  gnt_idx;
    logic [PTR_W-1:0]  ptr_after_gnt;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_data;
    logic              sel_vld;
    logic              sel_last;
    logic              slot_free;
    logic              accept;
    logic              beat_done;
    logic              stall_expired;

    rr_pick #(
        .N     (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req  (req_vld_i),
        .ptr  (rr_ptr_reg),
        .pick (pick)
    );

    // Owner's index and word, muxed from the registered one-hot grant.
    always_comb begin
        gnt_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_reg[i]) begin
                gnt_idx  = PTR_W'(i);
                sel_addr = req_addr_i[i*32 +: 32];
                sel_data = req_data_i[i*32 +: 32];
            end
        end
    end

    assign sel_vld       = |(gnt_reg & req_vld_i);
    assign sel_last      = |(gnt_reg & req_last_i);
    assign ptr_after_gnt = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
    assign slot_free     = !write_reg || !iWait_Master_Write;
    assign beat_done     = write_reg && !iWait_Master_Write;
    assign accept        = (state_reg == ARB_GRANT) && sel_vld && slot_free;
    assign req_rdy_o     = ((state_reg == ARB_GRANT) && slot_free) ? (gnt_reg & req_vld_i) : '0;

`ifdef WR_ARB_WAIT_TIMEOUT_EN
    localparam int TO_W = idx_width(TIMEOUT);

    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            timeout_reg, timeout_next;

    always_comb begin
        to_cnt_next   = to_cnt_reg;
        stall_expired = 1'b0;
        if (write_reg && iWait_Master_Write) begin
            if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
                stall_expired = 1'b1;
                to_cnt_next   = '0;
            end else begin
                to_cnt_next = to_cnt_reg + TO_W'(1);
            end
        end else if (beat_done) begin
            to_cnt_next = '0;
        end
        // A new error outranks a simultaneous clear.
        timeout_next = stall_expired ? 1'b1 : (clr_timeout_i ? 1'b0 : timeout_reg);
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            to_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            to_cnt_reg  <= to_cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign timeout_o = timeout_reg;
`else
    logic unused_cfg;

    assign stall_expired = 1'b0;
    assign timeout_o     = 1'b0;
    assign unused_cfg    = clr_timeout_i ^ (TIMEOUT > 0);
`endif

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        rr_ptr_next   = rr_ptr_reg;
        beat_cnt_next = beat_cnt_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        write_next    = write_reg;
        if (stall_expired) begin
            // Abandon the stalled word and hand the port on.
            state_next    = ARB_IDLE;
            gnt_next      = '0;
            write_next    = 1'b0;
            beat_cnt_next = '0;
            rr_ptr_next   = ptr_after_gnt;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (|req_vld_i) begin
                        gnt_next   = pick;
                        state_next = ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (accept) begin
                        addr_next     = sel_addr;
                        data_next     = sel_data;
                        write_next    = 1'b1;
                        beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                        if (sel_last || (beat_cnt_reg == LAST_BEAT)) begin
                            state_next = ARB_DRAIN;
                        end
                    end else if (slot_free) begin
                        write_next = 1'b0;
                    end
                end
                ARB_DRAIN: begin
                    if (beat_done) begin
                        write_next    = 1'b0;
                        gnt_next      = '0;
                        beat_cnt_next = '0;
                        rr_ptr_next   = ptr_after_gnt;
                        state_next    = ARB_IDLE;
                    end
                end
                default: state_next = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_reg    <= ARB_IDLE;
            gnt_reg      <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
            write_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            rr_ptr_reg   <= rr_ptr_next;
            beat_cnt_reg <= beat_cnt_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            write_reg    <= write_next;
        end
    end

    assign gnt_o                 = gnt_reg;
    assign oAddress_Master_Write = addr_reg;
    assign oData_Master_Write    = data_reg;
    assign oWrite_Master_Write   = write_reg;
    assign busy_o                = (state_reg != ARB_IDLE) || write_reg;

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Directed bench for wr_port_arbiter: reset, bursts, rotation, stalls, watchdog and mid-burst reset.
module tb_wr_port_arbiter;

    localparam int NREQ      = 3;
    localparam int MAX_BURST = 16;
    localparam int TIMEOUT   = 8;
    localparam logic [31:0] DMASK = 32'hA5A5_0000;

    logic              iClk = 1'b0;
    logic              iRstn = 1'b0;
    logic [NREQ-1:0]   req_vld_i;
    logic [NREQ*32-1:0] req_addr_i;
    logic [NREQ*32-1:0] req_data_i;
    logic [NREQ-1:0]   req_last_i;
    logic [NREQ-1:0]   req_rdy_o;
    logic [NREQ-1:0]   gnt_o;
    logic [31:0]       oAddress_Master_Write;
    logic [31:0]       oData_Master_Write;
    logic              oWrite_Master_Write;
    logic              iWait_Master_Write;
    logic              busy_o;
    logic              clr_timeout_i;
    logic              timeout_o;

    int compared   = 0;
    int mismatched = 0;

    always #5 iClk = ~iClk;

    wr_port_arbiter #(
        .NREQ      (NREQ),
        .MAX_BURST (MAX_BURST),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .iClk                  (iClk),
        .iRstn                 (iRstn),
        .req_vld_i             (req_vld_i),
        .req_addr_i            (req_addr_i),
        .req_data_i            (req_data_i),
        .req_last_i            (req_last_i),
        .req_rdy_o             (req_rdy_o),
        .gnt_o                 (gnt_o),
        .oAddress_Master_Write (oAddress_Master_Write),
        .oData_Master_Write    (oData_Master_Write),
        .oWrite_Master_Write   (oWrite_Master_Write),
        .iWait_Master_Write    (iWait_Master_Write),
        .busy_o                (busy_o),
        .clr_timeout_i         (clr_timeout_i),
        .timeout_o             (timeout_o)
    );

    // Present one word on requester r; data is the address scrambled with DMASK.
    task automatic drive(input int r, input logic vld, input logic [31:0] addr, input logic last);
        req_vld_i[r]            = vld;
        req_addr_i[r*32 +: 32]  = addr;
        req_data_i[r*32 +: 32]  = addr ^ DMASK;
        req_last_i[r]           = last;
    endtask

    task automatic test_reset();
        iRstn = 1'b0;
        repeat (2) @(negedge iClk);
        #1;
        compared++; if (gnt_o !== 3'b000) begin mismatched++; $display("FAIL rst_gnt: got %b want 000", gnt_o); end
        compared++; if (req_rdy_o !== 3'b000) begin mismatched++; $display("FAIL rst_rdy: got %b want 000", req_rdy_o); end
        compared++; if (oWrite_Master_Write !== 1'b0) begin mismatched++; $display("FAIL rst_write: got %b want 0", oWrite_Master_Write); end
        compared++; if (oAddress_Master_Write !== 32'h0) begin mismatched++; $display("FAIL rst_addr: got %h want 0", oAddress_Master_Write); end
        compared++; if (oData_Master_Write !== 32'h0) begin mismatched++; $display("FAIL rst_data: got %h want 0", oData_Master_Write); end
        compared++; if (busy_o !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        compared++; if (timeout_o !== 1'b0) begin mismatched++; $display("FAIL rst_timeout: got %b want 0", timeout_o); end
        @(negedge iClk);
        iRstn = 1'b1;
        $display("reset released");
    endtask

    task automatic test_single_burst();
        logic [31:0] exp_addr;
        @(negedge iClk);
        drive(0, 1'b1, 32'h1000, 1'b0);
        #1;
        compared++; if (gnt_o !== 3'b000) begin mismatched++; $display("FAIL sb_idle_gnt: got %b want 000", gnt_o); end
        @(negedge iClk);
        #1;
        compared++; if (gnt_o !== 3'b001) begin mismatched++; $display("FAIL sb_gnt: got %b want 001", gnt_o); end
        compared++; if (req_rdy_o !== 3'b001) begin mismatched++; $display("FAIL sb_rdy: got %b want 001", req_rdy_o); end
        for (int i = 0; i < 4; i++) begin
            @(negedge iClk);
            exp_addr = 32'h1000 + 32'(4 * i);
            compared++; if (oWrite_Master_Write !== 1'b1) begin mismatched++; $display("FAIL sb_write beat %0d: got %b want 1", i, oWrite_Master_Write); end
            compared++; if (oAddress_Master_Write !== exp_addr) begin mismatched++; $display("FAIL sb_addr beat %0d: got %h want %h", i, oAddress_Master_Write, exp_addr); end
            compared++; if (oData_Master_Write !== (exp_addr ^ DMASK)) begin mismatched++; $display("FAIL sb_data beat %0d: got %h want %h", i, oData_Master_Write, exp_addr ^ DMASK); end
            $display("single burst beat %0d addr=%h", i, oAddress_Master_Write);
            if (i < 3) drive(0, 1'b1, exp_addr + 32'h4, (i == 2));
            else       drive(0, 1'b0, 32'h0, 1'b0);
        end
        #1;
        compared++; if (gnt_o !== 3'b001) begin mismatched++; $display("FAIL sb_drain_gnt: got %b want 001", gnt_o); end
        @(negedge iClk);
        #1;
        compared++; if (oWrite_Master_Write !== 1'b0) begin mismatched++; $display("FAIL sb_end_write: got %b want 0", oWrite_Master_Write); end
        compared++; if (gnt_o !== 3'b000) begin mismatched++; $display("FAIL sb_end_gnt: got %b want 000", gnt_o); end
        compared++; if (busy_o !== 1'b0) begin mismatched++; $display("FAIL sb_end_busy: got %b want 0", busy_o); end
    endtask

    // rr_ptr is 1 after the single burst, so the rotation starts at requester 1.
    task automatic test_round_robin();
        int          exp_idx;
        logic [2:0]  exp_gnt;
        logic [31:0] exp_addr;
        @(negedge iClk);
        for (int r = 0; r < NREQ; r++) drive(r, 1'b1, 32'h0A00 + 32'(r * 16), 1'b1);
        for (int k = 0; k < 6; k++) begin
            exp_idx  = (1 + k) % NREQ;
            exp_gnt  = 3'(1 << exp_idx);
            exp_addr = 32'h0A00 + 32'(exp_idx * 16);
            @(negedge iClk);
            #1;
            compared++; if (gnt_o !== exp_gnt) begin mismatched++; $display("FAIL rr_gnt grant %0d: got %b want %b", k, gnt_o, exp_gnt); end
            compared++; if (req_rdy_o !== exp_gnt) begin mismatched++; $display("FAIL rr_rdy grant %0d: got %b want %b", k, req_rdy_o, exp_gnt); end
            $display("round robin grant %0d gnt=%b", k, gnt_o);
            @(negedge iClk);
            #1;
            compared++; if (oAddress_Master_Write !== exp_addr) begin mismatched++; $display("FAIL rr_addr grant %0d: got %h want %h", k, oAddress_Master_Write, exp_addr); end
            compared++; if (req_rdy_o !== 3'b000) begin mismatched++; $display("FAIL rr_drain_rdy grant %0d: got %b want 000", k, req_rdy_o); end
            @(negedge iClk);
            if (k == 5) req_vld_i = '0;
            #1;
            compared++; if (gnt_o !== 3'b000) begin mismatched++; $display("FAIL rr_idle_gnt grant %0d: got %b want 000", k, gnt_o); end
        end
    endtask

    // rr_ptr is 1: requester 1 streams without last while requester 2 waits.
    task automatic test_forced_rotation();
        @(negedge iClk);
        drive(1, 1'b1, 32'h2000, 1'b0);
        drive(2, 1'b1, 32'h3000, 1'b1);
        @(negedge iClk);
        #1;
        compared++; if (gnt_o !== 3'b010) begin mismatched++; $display("FAIL fr_gnt: got %b want 010", gnt_o); end
        for (int i = 0; i < MAX_BURST; i++) begin
            compared++; if (req_rdy_o !== 3'b010) begin mismatched++; $display("FAIL fr_rdy word %0d: got %b want 010", i, req_rdy_o); end
            @(negedge iClk);
            drive(1, 1'b1, 32'h2000 + 32'(4 * (i + 1)), 1'b0);
            #1;
        end
        compared++; if (oAddress_Master_Write !== 32'h203C) begin mismatched++; $display("FAIL fr_last_addr: got %h want 0000203c", oAddress_Master_Write); end
        compared++; if (req_rdy_o !== 3'b000) begin mismatched++; $display("FAIL fr_drain_rdy: got %b want 000", req_rdy_o); end
        compared++; if (gnt_o !== 3'b010) begin mismatched++; $display("FAIL fr_drain_gnt: got %b want 010", gnt_o); end
        @(negedge iClk);
        #1;
        compared++; if (gnt_o !== 3'b000) begin mismatched++; $display("FAIL fr_idle1: got %b want 000", gnt_o); end
        @(negedge iClk);
        #1;
        compared++; if (gnt_o !== 3'b100) begin mismatched++; $display("FAIL fr_gnt2: got %b want 100", gnt_o); end
        compared++; if (req_rdy_o !== 3'b100) begin mismatched++; $display("FAIL fr_rdy2: got %b want 100", req_rdy_o); end
        @(negedge iClk);
        drive(2, 1'b0, 32'h0, 1'b0);
        #1;
        compared++; if (oAddress_Master_Write !== 32'h3000) begin mismatched++; $display("FAIL fr_addr2: got %h want 00003000", oAddress_Master_Write); end
        $display("forced rotation served requester 2 addr=%h", oAddress_Master_Write);
        @(negedge iClk);
        #1;
        compared++; if (gnt_o !== 3'b000) begin mismatched++; $display("FAIL fr_idle2: got %b want 000", gnt_o); end
        @(negedge iClk);
        drive(1, 1'b1, 32'h2040, 1'b1);
        #1;
        compared++; if (gnt_o !== 3'b010) begin mismatched++; $display("FAIL fr_resume_gnt: got %b want 010", gnt_o); end
        @(negedge iClk);
        drive(1, 1'b0, 32'h0, 1'b0);
        #1;
        compared++; if (oAddress_Master_Write !== 32'h2040) begin mismatched++; $display("FAIL fr_resume_addr: got %h want 00002040", oAddress_Master_Write); end
        compared++; if (oData_Master_Write !== (32'h2040 ^ DMASK)) begin mismatched++; $display("FAIL fr_resume_data: got %h want %h", oData_Master_Write, 32'h2040 ^ DMASK); end
        @(negedge iClk);
        #1;
        compared++; if (busy_o !== 1'b0) begin mismatched++; $display("FAIL fr_end_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_wait_stall();
        @(negedge iClk);
        drive(2, 1'b1, 32'h4000, 1'b0);
        @(negedge iClk);
        #1;
        compared++; if (gnt_o !== 3'b100) begin mismatched++; $display("FAIL ws_gnt: got %b want 100", gnt_o); end
        @(negedge iClk);
        drive(2, 1'b1, 32'h4004, 1'b0);
        #1;
        compared++; if (oAddress_Master_Write !== 32'h4000) begin mismatched++; $display("FAIL ws_addr0: got %h want 00004000", oAddress_Master_Write); end
        @(negedge iClk);
        iWait_Master_Write = 1'b1;
        drive(2, 1'b1, 32'h4008, 1'b0);
        #1;
        compared++; if (req_rdy_o !== 3'b000) begin mismatched++; $display("FAIL ws_rdy_start: got %b want 000", req_rdy_o); end
        for (int k = 0; k < 5; k++) begin
            @(negedge iClk);
            #1;
            compared++; if (oAddress_Master_Write !== 32'h4004) begin mismatched++; $display("FAIL ws_hold_addr cycle %0d: got %h want 00004004", k, oAddress_Master_Write); end
            compared++; if (oData_Master_Write !== (32'h4004 ^ DMASK)) begin mismatched++; $display("FAIL ws_hold_data cycle %0d: got %h want %h", k, oData_Master_Write, 32'h4004 ^ DMASK); end
            compared++; if (oWrite_Master_Write !== 1'b1) begin mismatched++; $display("FAIL ws_hold_write cycle %0d: got %b want 1", k, oWrite_Master_Write); end
            compared++; if (req_rdy_o !== 3'b000) begin mismatched++; $display("FAIL ws_hold_rdy cycle %0d: got %b want 000", k, req_rdy_o); end
        end
        iWait_Master_Write = 1'b0;
        #1;
        compared++; if (req_rdy_o !== 3'b100) begin mismatched++; $display("FAIL ws_rdy_resume: got %b want 100", req_rdy_o); end
        @(negedge iClk);
        drive(2, 1'b1, 32'h400C, 1'b1);
        #1;
        compared++; if (oAddress_Master_Write !== 32'h4008) begin mismatched++; $display("FAIL ws_addr2: got %h want 00004008", oAddress_Master_Write); end
        @(negedge iClk);
        drive(2, 1'b0, 32'h0, 1'b0);
        #1;
        compared++; if (oAddress_Master_Write !== 32'h400C) begin mismatched++; $display("FAIL ws_addr3: got %h want 0000400c", oAddress_Master_Write); end
        @(negedge iClk);
        #1;
        compared++; if (oWrite_Master_Write !== 1'b0) begin mismatched++; $display("FAIL ws_end_write: got %b want 0", oWrite_Master_Write); end
        $display("wait stall burst finished");
    endtask

`ifdef WR_ARB_WAIT_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge iClk);
        drive(0, 1'b1, 32'h5000, 1'b1);
        iWait_Master_Write = 1'b1;
        @(negedge iClk);
        #1;
        compared++; if (gnt_o !== 3'b001) begin mismatched++; $display("FAIL to_gnt: got %b want 001", gnt_o); end
        @(negedge iClk);
        drive(0, 1'b0, 32'h0, 1'b0);
        repeat (7) @(negedge iClk);
        #1;
        compared++; if (timeout_o !== 1'b0) begin mismatched++; $display("FAIL to_early: got %b want 0", timeout_o); end
        compared++; if (oWrite_Master_Write !== 1'b1) begin mismatched++; $display("FAIL to_early_write: got %b want 1", oWrite_Master_Write); end
        @(negedge iClk);
        #1;
        compared++; if (timeout_o !== 1'b1) begin mismatched++; $display("FAIL to_set: got %b want 1", timeout_o); end
        compared++; if (oWrite_Master_Write !== 1'b0) begin mismatched++; $display("FAIL to_write: got %b want 0", oWrite_Master_Write); end
        compared++; if (busy_o !== 1'b0) begin mismatched++; $display("FAIL to_busy: got %b want 0", busy_o); end
        clr_timeout_i = 1'b1;
        iWait_Master_Write = 1'b0;
        @(negedge iClk);
        clr_timeout_i = 1'b0;
        #1;
        compared++; if (timeout_o !== 1'b0) begin mismatched++; $display("FAIL to_clear: got %b want 0", timeout_o); end
        $display("watchdog fired and cleared");
    endtask
`else
    task automatic test_timeout();
        @(negedge iClk);
        drive(0, 1'b1, 32'h5000, 1'b1);
        iWait_Master_Write = 1'b1;
        clr_timeout_i = 1'b1;
        @(negedge iClk);
        #1;
        compared++; if (gnt_o !== 3'b001) begin mismatched++; $display("FAIL to_gnt: got %b want 001", gnt_o); end
        @(negedge iClk);
        drive(0, 1'b0, 32'h0, 1'b0);
        repeat (12) @(negedge iClk);
        #1;
        compared++; if (timeout_o !== 1'b0) begin mismatched++; $display("FAIL to_off: got %b want 0", timeout_o); end
        compared++; if (oWrite_Master_Write !== 1'b1) begin mismatched++; $display("FAIL to_off_write: got %b want 1", oWrite_Master_Write); end
        compared++; if (oAddress_Master_Write !== 32'h5000) begin mismatched++; $display("FAIL to_off_addr: got %h want 00005000", oAddress_Master_Write); end
        iWait_Master_Write = 1'b0;
        clr_timeout_i = 1'b0;
        @(negedge iClk);
        #1;
        compared++; if (gnt_o !== 3'b000) begin mismatched++; $display("FAIL to_off_end_gnt: got %b want 000", gnt_o); end
        $display("long stall completed without watchdog");
    endtask
`endif

    // rr_ptr is 1 going in; after reset it must scan from 0 again.
    task automatic test_reset_mid_burst();
        @(negedge iClk);
        drive(1, 1'b1, 32'h6000, 1'b0);
        @(negedge iClk);
        #1;
        compared++; if (gnt_o !== 3'b010) begin mismatched++; $display("FAIL rm_gnt: got %b want 010", gnt_o); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge iClk);
            drive(1, 1'b1, 32'h6000 + 32'(4 * i), 1'b0);
        end
        #1;
        compared++; if (oAddress_Master_Write !== 32'h6008) begin mismatched++; $display("FAIL rm_beat3: got %h want 00006008", oAddress_Master_Write); end
        #2;
        iRstn = 1'b0;
        #1;
        compared++; if (oWrite_Master_Write !== 1'b0) begin mismatched++; $display("FAIL rm_write: got %b want 0", oWrite_Master_Write); end
        compared++; if (oAddress_Master_Write !== 32'h0) begin mismatched++; $display("FAIL rm_addr: got %h want 0", oAddress_Master_Write); end
        compared++; if (gnt_o !== 3'b000) begin mismatched++; $display("FAIL rm_gnt0: got %b want 000", gnt_o); end
        compared++; if (req_rdy_o !== 3'b000) begin mismatched++; $display("FAIL rm_rdy: got %b want 000", req_rdy_o); end
        compared++; if (busy_o !== 1'b0) begin mismatched++; $display("FAIL rm_busy: got %b want 0", busy_o); end
        @(negedge iClk);
        iRstn = 1'b1;
        drive(1, 1'b0, 32'h0, 1'b0);
        drive(0, 1'b1, 32'h7000, 1'b1);
        drive(2, 1'b1, 32'h7100, 1'b1);
        @(negedge iClk);
        #1;
        compared++; if (gnt_o !== 3'b001) begin mismatched++; $display("FAIL rm_first_gnt: got %b want 001", gnt_o); end
        @(negedge iClk);
        req_vld_i = '0;
        #1;
        compared++; if (oAddress_Master_Write !== 32'h7000) begin mismatched++; $display("FAIL rm_first_addr: got %h want 00007000", oAddress_Master_Write); end
        @(negedge iClk);
        $display("post-reset grant completed");
    endtask

    initial begin
        req_vld_i          = '0;
        req_addr_i         = '0;
        req_data_i         = '0;
        req_last_i         = '0;
        iWait_Master_Write = 1'b0;
        clr_timeout_i      = 1'b0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_forced_rotation();
        test_wait_stall();
        test_timeout();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
